// File: rtl/dense_layer_sm_if.sv
// Bus bundle for dense_layer_sm: operand vectors in, result vector and done flag out.
interface dense_layer_sm_if #(
  parameter int unsigned BITSIZE = 24,
  parameter int unsigned N_IN    = 10,
  parameter int unsigned N_OUT   = 6
);
  logic [BITSIZE*N_IN-1:0]       x;
  logic [BITSIZE*N_IN*N_OUT-1:0] w;
  logic [BITSIZE*N_OUT-1:0]      b;
  logic [BITSIZE*N_OUT-1:0]      y;
  logic                          valid;

  modport master (output x, output w, output b, input y, input valid);
  modport slave  (input x, input w, input b, output y, output valid);
endinterface

// File: rtl/dense_layer_sm.sv
// Fully-connected layer over signed-magnitude fixed point: one MAC per output per
// cycle, one computation per reset release, result held until the next reset.
module dense_layer_sm #(
  parameter int unsigned BITSIZE = 24,
  parameter int unsigned FRAC    = 16,
  parameter int unsigned N_IN    = 10,
  parameter int unsigned N_OUT   = 6
) (
  input  logic           clk,
  input  logic           reset,
  dense_layer_sm_if.slave bus
);

  localparam int unsigned MW   = BITSIZE - 1;
  localparam int unsigned PW   = 2 * MW;
  localparam int unsigned AW   = 2 * BITSIZE + $clog2(N_IN + 1);
  localparam int unsigned CW   = ($clog2(N_IN + 1) < 1) ? 1 : $clog2(N_IN + 1);
  localparam logic [AW-1:0] MAXM = AW'((64'(1) << MW) - 64'(1));

  typedef enum logic {S_RUN, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic signed [AW-1:0]      acc_q [N_OUT];
  logic signed [AW-1:0]      acc_d [N_OUT];
  logic signed [AW-1:0]      prod  [N_OUT];
  logic [BITSIZE*N_OUT-1:0]  y_q, y_d;
  logic                      valid_q, valid_d;
  logic [BITSIZE-1:0]        xk;
  logic [BITSIZE-1:0]        wk    [N_OUT];

  // Exact signed-magnitude to two's-complement conversion (-0 maps to 0).
  function automatic logic signed [AW-1:0] sm_to_s(input logic [BITSIZE-1:0] v);
    logic [AW-1:0] mag;
    mag = AW'(v[MW-1:0]);
    return v[MW] ? -$signed(mag) : $signed(mag);
  endfunction

  // Fixed-point product: full-width magnitude multiply, truncating shift, XOR sign.
  function automatic logic signed [AW-1:0] sm_mul(input logic [BITSIZE-1:0] a,
                                                  input logic [BITSIZE-1:0] c);
    logic [PW-1:0] full;
    logic [AW-1:0] mag;
    full = PW'(a[MW-1:0]) * PW'(c[MW-1:0]);
    mag  = AW'(full >> FRAC);
    return (a[MW] ^ c[MW]) ? -$signed(mag) : $signed(mag);
  endfunction

  // Clamp to the signed-magnitude range; zero always comes out as +0.
  function automatic logic [BITSIZE-1:0] sat(input logic signed [AW-1:0] s);
    logic          neg;
    logic [AW-1:0] mag;
    neg = s[AW-1];
    mag = neg ? $unsigned(-s) : $unsigned(s);
    if (mag > MAXM) mag = MAXM;
    if (mag == '0) return '0;
    return {neg, mag[MW-1:0]};
  endfunction

  // Select the operands for the current input index and form each neuron's product.
  always_comb begin
    xk = '0;
    for (int unsigned k = 0; k < N_IN; k++) begin
      if (cnt_q == CW'(k)) xk = bus.x[BITSIZE*k +: BITSIZE];
    end
    for (int unsigned j = 0; j < N_OUT; j++) begin
      wk[j] = '0;
      for (int unsigned k = 0; k < N_IN; k++) begin
        if (cnt_q == CW'(k)) wk[j] = bus.w[BITSIZE*(j*N_IN+k) +: BITSIZE];
      end
      prod[j] = sm_mul(xk, wk[j]);
    end
  end

  // Next-state: accumulate N_IN terms, then bias, saturate and latch once.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    valid_d = valid_q;
    for (int unsigned j = 0; j < N_OUT; j++) acc_d[j] = acc_q[j];
    case (state_q)
      S_RUN: begin
        if (cnt_q == CW'(N_IN)) begin
          for (int unsigned j = 0; j < N_OUT; j++) begin
            y_d[BITSIZE*j +: BITSIZE] = sat(acc_q[j] + sm_to_s(bus.b[BITSIZE*j +: BITSIZE]));
          end
          valid_d = 1'b1;
          state_d = S_DONE;
        end else begin
          for (int unsigned j = 0; j < N_OUT; j++) acc_d[j] = acc_q[j] + prod[j];
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
    endcase
  end

  // State register; reset low clears everything and arms a fresh computation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      for (int unsigned j = 0; j < N_OUT; j++) acc_q[j] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      for (int unsigned j = 0; j < N_OUT; j++) acc_q[j] <= acc_d[j];
    end
  end

  assign bus.y     = y_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_dense_layer_sm.sv
// Self-checking bench for dense_layer_sm with a plain-arithmetic reference model.
module tb_dense_layer_sm;

  localparam int BS = 24;
  localparam int NI = 10;
  localparam int NO = 6;
  localparam int MAXE = 3 * NI + 5;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  logic [BS-1:0] xa [NI];
  logic [BS-1:0] wa [NO][NI];
  logic [BS-1:0] ba [NO];

  dense_layer_sm_if #(.BITSIZE(BS), .N_IN(NI), .N_OUT(NO)) bus ();

  dense_layer_sm #(.BITSIZE(BS), .FRAC(16), .N_IN(NI), .N_OUT(NO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: y_j = SAT(sum_k P(x_k, w_jk) + b_j) using 64-bit integers.
  function automatic logic [BS*NO-1:0] model_y();
    logic [BS*NO-1:0] r;
    longint acc, p, m;
    r = '0;
    for (int j = 0; j < NO; j++) begin
      acc = 0;
      for (int k = 0; k < NI; k++) begin
        p = (longint'(xa[k][BS-2:0]) * longint'(wa[j][k][BS-2:0])) / 65536;
        if (xa[k][BS-1] ^ wa[j][k][BS-1]) p = -p;
        acc += p;
      end
      acc += ba[j][BS-1] ? -longint'(ba[j][BS-2:0]) : longint'(ba[j][BS-2:0]);
      m = (acc < 0) ? -acc : acc;
      if (m > 64'h7FFFFF) m = 64'h7FFFFF;
      if (m == 0) r[BS*j +: BS] = '0;
      else        r[BS*j +: BS] = {(acc < 0), 23'(m)};
    end
    return r;
  endfunction

  task automatic drive_inputs();
    for (int k = 0; k < NI; k++) bus.x[BS*k +: BS] = xa[k];
    for (int j = 0; j < NO; j++) begin
      bus.b[BS*j +: BS] = ba[j];
      for (int k = 0; k < NI; k++) bus.w[BS*(j*NI+k) +: BS] = wa[j][k];
    end
  endtask

  task automatic clear_arrays();
    for (int k = 0; k < NI; k++) xa[k] = '0;
    for (int j = 0; j < NO; j++) begin
      ba[j] = '0;
      for (int k = 0; k < NI; k++) wa[j][k] = '0;
    end
  endtask

  task automatic rand_arrays(input bit full);
    for (int k = 0; k < NI; k++)
      xa[k] = full ? BS'($urandom) : {1'($urandom_range(0, 1)), 23'($urandom_range(0, 'h3FFFF))};
    for (int j = 0; j < NO; j++) begin
      ba[j] = full ? BS'($urandom) : {1'($urandom_range(0, 1)), 23'($urandom_range(0, 'h3FFFF))};
      for (int k = 0; k < NI; k++)
        wa[j][k] = full ? BS'($urandom) : {1'($urandom_range(0, 1)), 23'($urandom_range(0, 'h3FFFF))};
    end
  endtask

  // Pulse reset for one cycle with the current arrays applied; release on a falling edge.
  task automatic start_compute();
    @(negedge clk);
    reset = 1'b0;
    drive_inputs();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Edge index (0 = first edge after release) on which valid was first seen high.
  task automatic wait_valid(output int fe);
    fe = -1;
    for (int e = 0; e < MAXE; e++) begin
      @(posedge clk);
      #1;
      if (bus.valid === 1'b1) begin
        fe = e;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int fe;
    rand_arrays(1'b1);
    @(negedge clk);
    reset = 1'b0;
    drive_inputs();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.y !== '0 || bus.valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: y=%h valid=%b required y=0 valid=0", bus.y, bus.valid);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    wait_valid(fe);
    checks++;
    if (fe !== NI) begin
      errors++;
      $display("FAIL reset_latency: valid edge=%0d required %0d", fe, NI);
    end
    checks++;
    if (bus.y !== model_y()) begin
      errors++;
      $display("FAIL reset_result: y=%h required %h", bus.y, model_y());
    end
  endtask

  task automatic test_unity();
    int fe;
    logic [BS*NO-1:0] exp_y;
    clear_arrays();
    for (int k = 0; k < NI; k++) xa[k] = 24'h010000;
    for (int j = 0; j < NO; j++) for (int k = 0; k < NI; k++) wa[j][k] = 24'h008000;
    exp_y = {NO{24'h050000}};
    start_compute();
    wait_valid(fe);
    checks++;
    if (fe !== NI) begin
      errors++;
      $display("FAIL unity_latency: valid edge=%0d required %0d", fe, NI);
    end
    checks++;
    if (bus.y !== exp_y) begin
      errors++;
      $display("FAIL unity_result: y=%h required %h", bus.y, exp_y);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) bus.x[BS*k +: BS] = BS'($urandom);
      @(posedge clk);
      #1;
      checks++;
      if (bus.y !== exp_y || bus.valid !== 1'b1) begin
        errors++;
        $display("FAIL unity_hold: y=%h valid=%b required %h valid=1", bus.y, bus.valid, exp_y);
      end
    end
  endtask

  task automatic test_signed();
    int fe;
    logic [BS*NO-1:0] exp_y;
    clear_arrays();
    for (int k = 1; k < NI; k++) xa[k] = BS'($urandom);
    xa[0] = 24'h820000;
    wa[0][0] = 24'h018000;
    ba[0] = 24'h010000;
    exp_y = '0;
    exp_y[BS-1:0] = 24'h820000;
    start_compute();
    wait_valid(fe);
    checks++;
    if (fe !== NI || bus.y !== exp_y) begin
      errors++;
      $display("FAIL signed: edge=%0d y=%h required edge=%0d y=%h", fe, bus.y, NI, exp_y);
    end
  endtask

  task automatic test_saturation();
    int fe;
    logic [BS*NO-1:0] exp_y;
    clear_arrays();
    for (int k = 0; k < NI; k++) begin
      xa[k] = 24'h640000;
      wa[0][k] = 24'h010000;
      wa[1][k] = 24'h810000;
    end
    exp_y = '0;
    exp_y[BS-1:0]    = 24'h7FFFFF;
    exp_y[2*BS-1:BS] = 24'hFFFFFF;
    start_compute();
    wait_valid(fe);
    checks++;
    if (fe !== NI || bus.y !== exp_y) begin
      errors++;
      $display("FAIL saturation: edge=%0d y=%h required edge=%0d y=%h", fe, bus.y, NI, exp_y);
    end
  endtask

  task automatic test_neg_zero();
    int fe;
    logic [BS*NO-1:0] exp_y;
    clear_arrays();
    xa[0] = 24'h010000;
    wa[0][0] = 24'h010000;
    ba[0] = 24'h810000;
    exp_y = '0;
    start_compute();
    wait_valid(fe);
    checks++;
    if (fe !== NI || bus.y !== exp_y) begin
      errors++;
      $display("FAIL neg_zero: edge=%0d y=%h required edge=%0d y=%h", fe, bus.y, NI, exp_y);
    end
    clear_arrays();
    xa[0] = 24'h000001;
    wa[0][0] = 24'h008000;
    ba[0] = 24'h030000;
    exp_y = '0;
    exp_y[BS-1:0] = 24'h030000;
    start_compute();
    wait_valid(fe);
    checks++;
    if (fe !== NI || bus.y !== exp_y) begin
      errors++;
      $display("FAIL truncation: edge=%0d y=%h required edge=%0d y=%h", fe, bus.y, NI, exp_y);
    end
  endtask

  task automatic test_mid_reset();
    int fe;
    // Asynchronous clear of a held result, between clock edges.
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.y !== '0 || bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL async_clear: y=%h valid=%b required y=0 valid=0", bus.y, bus.valid);
    end
    rand_arrays(1'b0);
    drive_inputs();
    @(negedge clk);
    reset = 1'b1;
    for (int e = 0; e < 6; e++) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.y !== '0 || bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_clear: y=%h valid=%b required y=0 valid=0", bus.y, bus.valid);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    wait_valid(fe);
    checks++;
    if (fe !== NI) begin
      errors++;
      $display("FAIL mid_latency: valid edge=%0d required %0d", fe, NI);
    end
    checks++;
    if (bus.y !== model_y()) begin
      errors++;
      $display("FAIL mid_result: y=%h required %h", bus.y, model_y());
    end
  endtask

  task automatic test_random();
    int fe;
    for (int r = 0; r < 10; r++) begin
      rand_arrays(r[0]);
      start_compute();
      wait_valid(fe);
      checks++;
      if (fe !== NI || bus.y !== model_y()) begin
        errors++;
        $display("FAIL random_%0d: edge=%0d y=%h required edge=%0d y=%h", r, fe, bus.y, NI, model_y());
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    clear_arrays();
    drive_inputs();
    test_reset();
    test_unity();
    test_signed();
    test_saturation();
    test_neg_zero();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
